// File: rtl/trace_uart_tx.sv
// Serial trace transmitter: snapshots instruction and both register read ports, sends one 13-byte UART 8N1 frame.
// Latency: line drops to the start bit one edge after the capture strobe. Captures that arrive while a frame is in flight are counted, not queued.
module trace_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        iCapture,
    input  logic [31:0] iInstruction,
    input  logic [31:0] iRead1,
    input  logic [31:0] iRead2,
    output logic        oTx,
    output logic        oBusy,
    output logic [7:0]  oDropCount
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    state_t       state;
    logic [15:0]  clk_cnt;
    logic [2:0]   bit_idx;
    logic [3:0]   byte_idx;
    logic [103:0] frame;

    logic         bit_end;
    logic [2:0]   next_bit;
    logic [7:0]   cur_byte;

    assign bit_end  = (clk_cnt == LAST_CLK);
    assign next_bit = bit_idx + 3'd1;
    // The byte on the wire always sits in the top of the frame register.
    assign cur_byte = frame[103:96];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            frame      <= '0;
            oTx        <= 1'b1;
            oBusy      <= 1'b0;
            oDropCount <= '0;
        end else begin
            if (oBusy && iCapture && (oDropCount != 8'hFF))
                oDropCount <= oDropCount + 8'd1;

            case (state)
                IDLE: begin
                    if (iCapture) begin
                        frame    <= {SYNC_BYTE, iInstruction, iRead1, iRead2};
                        state    <= START;
                        oTx      <= 1'b0;
                        oBusy    <= 1'b1;
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        oTx     <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            oTx     <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= next_bit;
                            oTx     <= cur_byte[next_bit];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (byte_idx == 4'd12) begin
                            byte_idx <= '0;
                            oBusy    <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            byte_idx <= byte_idx + 4'd1;
                            frame    <= {frame[95:0], 8'h00};
                            oTx      <= 1'b0;
                            state    <= START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_uart_tx.sv
// Bench for trace_uart_tx: two instances (4 and 2 clocks per bit), UART decoders feeding a byte scoreboard.
module tb_trace_uart_tx;

    logic        clk;
    logic        rst_n, rst1_n;
    logic        cap0, cap1;
    logic [31:0] ins0, rd1_0, rd2_0;
    logic [31:0] ins1, rd1_1, rd2_1;
    logic        tx0, busy0, tx1, busy1;
    logic [7:0]  drop0, drop1;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic done1 = 1'b0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    logic       active[2];
    logic       lvl[2];
    logic       glitch[2];
    int         mcyc[2];
    int         bitn[2];
    logic [7:0] cur[2];

    trace_uart_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut0 (
        .clock(clk), .reset_n(rst_n), .iCapture(cap0),
        .iInstruction(ins0), .iRead1(rd1_0), .iRead2(rd2_0),
        .oTx(tx0), .oBusy(busy0), .oDropCount(drop0)
    );

    trace_uart_tx #(.CLKS_PER_BIT(2), .SYNC_BYTE(8'hA5)) dut1 (
        .clock(clk), .reset_n(rst1_n), .iCapture(cap1),
        .iInstruction(ins1), .iRead1(rd1_1), .iRead2(rd2_1),
        .oTx(tx1), .oBusy(busy1), .oDropCount(drop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_frame(input int ch, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [103:0] f;
        f = {8'hA5, a, b, c};
        for (int i = 12; i >= 0; i--) begin
            if (ch == 0) exp_q0.push_back(f[i*8 +: 8]);
            else         exp_q1.push_back(f[i*8 +: 8]);
        end
    endtask

    // Decoder: every bit must hold for exactly cpb samples; one sample per falling edge.
    task automatic mon_step(input int ch, input logic tx, input logic rn, input int cpb);
        logic [7:0] e;
        if (!rn) begin
            active[ch] = 1'b0;
        end else if (!active[ch]) begin
            if (tx === 1'b0) begin
                active[ch] = 1'b1;
                lvl[ch]    = 1'b0;
                glitch[ch] = 1'b0;
                mcyc[ch]   = 1;
                bitn[ch]   = 0;
                cur[ch]    = 8'h00;
            end
        end else begin
            if (mcyc[ch] == 0) lvl[ch] = tx;
            else if (tx !== lvl[ch]) glitch[ch] = 1'b1;
            mcyc[ch]++;
        end
        if (rn && active[ch] && mcyc[ch] == cpb) begin
            mcyc[ch] = 0;
            if (bitn[ch] >= 1 && bitn[ch] <= 8) cur[ch][bitn[ch]-1] = lvl[ch];
            if (bitn[ch] == 9) begin
                active[ch] = 1'b0;
                chk($sformatf("ch%0d framing", ch), {30'd0, glitch[ch], lvl[ch]}, 32'd1);
                if ((ch == 0 && exp_q0.size() == 0) || (ch == 1 && exp_q1.size() == 0)) begin
                    checks++;
                    fails++;
                    $display("FAIL ch%0d unexpected byte: got %0h, expected none", ch, cur[ch]);
                end else begin
                    e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk($sformatf("ch%0d byte", ch), {24'd0, cur[ch]}, {24'd0, e});
                end
            end else begin
                bitn[ch]++;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, tx0, rst_n, 4);
        mon_step(1, tx1, rst1_n, 2);
    end

    task automatic wait_idle0(input int bound);
        int n;
        n = 0;
        while (busy0 && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ch0 idle within bound", {31'd0, busy0}, 32'd0);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic change);
        int n;
        ins0 = a; rd1_0 = b; rd2_0 = c;
        push_frame(0, a, b, c);
        cap0 = 1'b1;
        @(posedge clk); #1;
        cap0 = 1'b0;
        chk("capture busy", {31'd0, busy0}, 32'd1);
        chk("capture start bit", {31'd0, tx0}, 32'd0);
        n = 0;
        while (n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (change && n == 1) begin
                ins0 = 32'h12345678; rd1_0 = 32'h12345678; rd2_0 = 32'h12345678;
            end
            if (!busy0) break;
        end
        chk("busy length", n, 520);
        chk("idle line after frame", {31'd0, tx0}, 32'd1);
    endtask

    initial begin
        active = '{1'b0, 1'b0};
        mcyc   = '{0, 0};
        bitn   = '{0, 0};
        rst_n  = 1'b0;
        cap0   = 1'b1;
        ins0   = 32'h0; rd1_0 = 32'h0; rd2_0 = 32'h0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset tx", {31'd0, tx0}, 32'd1);
            chk("reset busy", {31'd0, busy0}, 32'd0);
            chk("reset drop", {24'd0, drop0}, 32'd0);
        end
        cap0  = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", {31'd0, busy0}, 32'd0);

        send_frame(32'h00A00093, 32'h00000005, 32'hFFFFFFFF, 1'b0);
        send_frame(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 1'b1);

        // Capture held high: first frame, drops saturate, second frame one edge after the first ends.
        ins0 = 32'h0F1E2D3C; rd1_0 = 32'h80000001; rd2_0 = 32'h00FF00FF;
        push_frame(0, ins0, rd1_0, rd2_0);
        push_frame(0, ins0, rd1_0, rd2_0);
        cap0 = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (i == 0)   begin chk("hold accept busy", {31'd0, busy0}, 32'd1); chk("hold drop0", {24'd0, drop0}, 32'd0); end
            if (i == 254) chk("drop 254", {24'd0, drop0}, 32'd254);
            if (i == 255) chk("drop 255", {24'd0, drop0}, 32'd255);
            if (i == 519) chk("hold still busy", {31'd0, busy0}, 32'd1);
            if (i == 520) begin chk("hold frame end", {31'd0, busy0}, 32'd0); chk("hold end tx", {31'd0, tx0}, 32'd1); end
            if (i == 521) begin chk("hold second accept", {31'd0, busy0}, 32'd1); chk("hold second start", {31'd0, tx0}, 32'd0); end
            if (i == 599) chk("drop saturated", {24'd0, drop0}, 32'd255);
        end
        cap0 = 1'b0;
        wait_idle0(1000);
        chk("drop held", {24'd0, drop0}, 32'd255);

        // Mid-frame reset abandons the frame; bytes completed before it are still checked.
        ins0 = 32'h11223344; rd1_0 = 32'h55667788; rd2_0 = 32'h99AABBCC;
        push_frame(0, ins0, rd1_0, rd2_0);
        cap0 = 1'b1;
        @(posedge clk); #1;
        cap0 = 1'b0;
        for (int i = 1; i < 200; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset tx", {31'd0, tx0}, 32'd1);
        chk("midreset busy", {31'd0, busy0}, 32'd0);
        chk("midreset drop", {24'd0, drop0}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q0.delete();
        @(posedge clk); #1;
        chk("no trailing bits", {31'd0, tx0}, 32'd1);
        send_frame(32'hA5A5A55A, 32'h00000000, 32'h7FFFFFFE, 1'b0);

        for (int n = 0; n < 5000 && !done1; n++) @(posedge clk);
        chk("ch1 finished", {31'd0, done1}, 32'd1);
        repeat (4) @(posedge clk);
        chk("ch0 scoreboard drained", exp_q0.size(), 0);
        chk("ch1 scoreboard drained", exp_q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Two clocks per bit with capture always high: back-to-back frames 261 edges apart.
    initial begin
        int   rises;
        int   last;
        logic prev;
        rst1_n = 1'b0;
        cap1   = 1'b0;
        ins1 = 32'hCAFEF00D; rd1_1 = 32'h00000001; rd2_1 = 32'h80000000;
        repeat (2) @(posedge clk);
        #1;
        rst1_n = 1'b1;
        for (int f = 0; f < 4; f++) push_frame(1, ins1, rd1_1, rd2_1);
        cap1  = 1'b1;
        rises = 0;
        last  = 0;
        prev  = 1'b0;
        for (int n = 0; n < 1200 && rises < 4; n++) begin
            @(posedge clk); #1;
            if (busy1 && !prev) begin
                chk("ch1 start bit", {31'd0, tx1}, 32'd0);
                if (rises > 0) chk("ch1 frame spacing", cyc - last, 261);
                last = cyc;
                rises++;
            end
            prev = busy1;
        end
        cap1 = 1'b0;
        chk("ch1 frames started", rises, 4);
        for (int n = 0; n < 400 && busy1; n++) begin
            @(posedge clk); #1;
        end
        chk("ch1 idle", {31'd0, busy1}, 32'd0);
        chk("ch1 drop saturated", {24'd0, drop1}, 32'd255);
        done1 = 1'b1;
    end

endmodule
